// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the MIPS hazard / PC-sequencing controller.
// Optional forwarding build: PIPELINE_CTRL_FORWARDING_EN.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        PCSRC_PC4    = 3'd0,
        PCSRC_BRANCH = 3'd1,
        PCSRC_JUMP   = 3'd2,
        PCSRC_JR     = 3'd3,
        PCSRC_ILLOP  = 3'd4,
        PCSRC_XADR   = 3'd5
    } pcsrc_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

    // Register $0 never creates a dependency.
    function automatic logic raw_hit(
        input logic       used,
        input logic [4:0] src,
        input logic       wr,
        input logic [4:0] dst
    );
        return used && (src != 5'd0) && wr && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_raw_compare.sv
// Source-vs-destination match of the ID operands against EX and MEM.
// Purely combinational; one hit per operand per stage.
module raw_compare
    import pipeline_ctrl_pkg::*;
(
    input  logic       i_use_rs,
    input  logic       i_use_rt,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd_ex,
    input  logic       i_wr_ex,
    input  logic [4:0] i_rd_mem,
    input  logic       i_wr_mem,
    output logic       o_ex_hit_a,
    output logic       o_mem_hit_a,
    output logic       o_ex_hit_b,
    output logic       o_mem_hit_b
);

    assign o_ex_hit_a  = raw_hit(i_use_rs, i_rs, i_wr_ex,  i_rd_ex);
    assign o_mem_hit_a = raw_hit(i_use_rs, i_rs, i_wr_mem, i_rd_mem);
    assign o_ex_hit_b  = raw_hit(i_use_rt, i_rt, i_wr_ex,  i_rd_ex);
    assign o_mem_hit_b = raw_hit(i_use_rt, i_rt, i_wr_mem, i_rd_mem);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and PC-source controller beside the ID stage.
// Define PIPELINE_CTRL_FORWARDING_EN for bypass paths + load-use stall.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] ILLOP_ADDR = ILLOP_VEC,
    parameter logic [31:0] XADR_ADDR  = XADR_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic        jump_id,
    input  logic        jr_id,
    input  logic        illop_id,
    input  logic [31:0] pc_id,
    input  logic [4:0]  rd_ex,
    input  logic        regwrite_ex,
    input  logic        memread_ex,
    input  logic        branch_taken_ex,
    input  logic [4:0]  rd_mem,
    input  logic        regwrite_mem,
    input  logic        irq,
    output logic [2:0]  pcsrc,
    output logic        stall,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        exc_save,
    output logic        irq_pending
);

    logic       w_ex_a;
    logic       w_mem_a;
    logic       w_ex_b;
    logic       w_mem_b;
    logic [1:0] w_need;
    logic       w_unused;

    state_e     r_state;
    logic [1:0] r_stall_cnt;
    logic       r_irq_pending;

    raw_compare u_raw (
        .i_use_rs    (use_rs_id),
        .i_use_rt    (use_rt_id),
        .i_rs        (rs_id),
        .i_rt        (rt_id),
        .i_rd_ex     (rd_ex),
        .i_wr_ex     (regwrite_ex),
        .i_rd_mem    (rd_mem),
        .i_wr_mem    (regwrite_mem),
        .o_ex_hit_a  (w_ex_a),
        .o_mem_hit_a (w_mem_a),
        .o_ex_hit_b  (w_ex_b),
        .o_mem_hit_b (w_mem_b)
    );

`ifdef PIPELINE_CTRL_FORWARDING_EN
    assign w_need = (memread_ex && (w_ex_a || w_ex_b)) ? 2'd1 : 2'd0;
    assign w_unused = ^{pc_id[30:0], ILLOP_ADDR, XADR_ADDR};
`else
    // Write-first regfile: only EX and MEM producers are hazards.
    assign w_need = (w_ex_a || w_ex_b)   ? 2'd2 :
                    (w_mem_a || w_mem_b) ? 2'd1 : 2'd0;
    assign w_unused = ^{pc_id[30:0], ILLOP_ADDR, XADR_ADDR, memread_ex};
`endif

    logic w_branch;
    logic w_take_irq;
    logic w_preempt;
    logic w_stall;
    logic w_ev_jr;
    logic w_ev_j;

    assign w_branch   = branch_taken_ex && !illop_id;
    assign w_take_irq = r_irq_pending && !pc_id[31]
                        && !illop_id && !branch_taken_ex;
    assign w_preempt  = illop_id || branch_taken_ex || w_take_irq;
    assign w_stall    = ((r_state == ST_STALL) || (w_need != 2'd0))
                        && !w_preempt;
    assign w_ev_jr    = jr_id && !w_preempt && !w_stall;
    assign w_ev_j     = jump_id && !jr_id && !w_preempt && !w_stall;

    always_comb begin
        pcsrc       = PCSRC_PC4;
        stall       = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        exc_save    = 1'b0;
        if (!reset) begin
            unique case (1'b1)
                illop_id: begin
                    pcsrc       = PCSRC_ILLOP;
                    flush_if_id = 1'b1;
                    exc_save    = 1'b1;
                end
                w_branch: begin
                    pcsrc       = PCSRC_BRANCH;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
                w_take_irq: begin
                    pcsrc       = PCSRC_XADR;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    exc_save    = 1'b1;
                end
                w_stall: begin
                    stall = 1'b1;
                end
                w_ev_jr: begin
                    pcsrc       = PCSRC_JR;
                    flush_if_id = 1'b1;
                end
                w_ev_j: begin
                    pcsrc       = PCSRC_JUMP;
                    flush_if_id = 1'b1;
                end
                default: begin
                    pcsrc = PCSRC_PC4;
                end
            endcase
        end
    end

`ifdef PIPELINE_CTRL_FORWARDING_EN
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset) begin
            if (w_ex_a)       fwd_a = FWD_EXMEM;
            else if (w_mem_a) fwd_a = FWD_MEMWB;
            if (w_ex_b)       fwd_b = FWD_EXMEM;
            else if (w_mem_b) fwd_b = FWD_MEMWB;
        end
    end
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign irq_pending = r_irq_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_stall_cnt   <= 2'd0;
            r_irq_pending <= 1'b0;
        end else begin
            r_irq_pending <= (r_irq_pending && !w_take_irq) || irq;
            unique case (r_state)
                ST_RUN: begin
                    if (!w_preempt && (w_need > 2'd1)) begin
                        r_state     <= ST_STALL;
                        r_stall_cnt <= w_need;
                    end
                end
                ST_STALL: begin
                    // Leaving when the count would reach 1.
                    if (w_preempt || (r_stall_cnt <= 2'd2)) begin
                        r_state     <= ST_RUN;
                        r_stall_cnt <= 2'd0;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_stall_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Covers both PIPELINE_CTRL_FORWARDING_EN builds.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_id, rt_id, rd_ex, rd_mem;
    logic        use_rs_id, use_rt_id, jump_id, jr_id, illop_id;
    logic [31:0] pc_id;
    logic        regwrite_ex, memread_ex, branch_taken_ex;
    logic        regwrite_mem, irq;
    logic [2:0]  pcsrc;
    logic        stall, flush_if_id, flush_id_ex, exc_save, irq_pending;
    logic [1:0]  fwd_a, fwd_b;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .jump_id(jump_id), .jr_id(jr_id), .illop_id(illop_id),
        .pc_id(pc_id),
        .rd_ex(rd_ex), .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
        .branch_taken_ex(branch_taken_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
        .irq(irq),
        .pcsrc(pcsrc), .stall(stall),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .exc_save(exc_save), .irq_pending(irq_pending)
    );

    task automatic idle();
        rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
        jump_id = 0; jr_id = 0; illop_id = 0; pc_id = 32'h0040_0000;
        rd_ex = 0; regwrite_ex = 0; memread_ex = 0; branch_taken_ex = 0;
        rd_mem = 0; regwrite_mem = 0; irq = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; illop_id = 1; irq = 1; jump_id = 1;
        rd_ex = 3; regwrite_ex = 1; rs_id = 3; use_rs_id = 1;
        #1;
        checks++;
        if (pcsrc !== 3'd0) begin errs++;
            $display("FAIL rst_pcsrc got=%0d exp=0", pcsrc); end
        checks++;
        if ({stall, flush_if_id, flush_id_ex, exc_save} !== 4'b0) begin errs++;
            $display("FAIL rst_ctl got=%b exp=0000",
                     {stall, flush_if_id, flush_id_ex, exc_save}); end
        tick();
        checks++;
        if (irq_pending !== 1'b0) begin errs++;
            $display("FAIL rst_pend got=%b exp=0", irq_pending); end
        checks++;
        if (dut.r_state !== ST_RUN) begin errs++;
            $display("FAIL rst_state got=%0d exp=0", dut.r_state); end
        idle(); reset = 0;
        tick();
        checks++;
        if (irq_pending !== 1'b0 || stall !== 1'b0) begin errs++;
            $display("FAIL rst_after got=%b%b exp=00", irq_pending, stall); end
    endtask

    task automatic test_load_use();
        idle();
        rd_ex = 8; regwrite_ex = 1; memread_ex = 1; rs_id = 8; use_rs_id = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errs++;
            $display("FAIL lu_stall1 got=%b exp=1", stall); end
        tick();
        rd_ex = 0; regwrite_ex = 0; memread_ex = 0;
        rd_mem = 8; regwrite_mem = 1;
        #1;
`ifdef PIPELINE_CTRL_FORWARDING_EN
        checks++;
        if (stall !== 1'b0) begin errs++;
            $display("FAIL lu_stall2 got=%b exp=0", stall); end
        checks++;
        if (fwd_a !== 2'd2) begin errs++;
            $display("FAIL lu_fwd got=%0d exp=2", fwd_a); end
`else
        checks++;
        if (stall !== 1'b1) begin errs++;
            $display("FAIL lu_stall2 got=%b exp=1", stall); end
        checks++;
        if (fwd_a !== 2'd0) begin errs++;
            $display("FAIL lu_fwd got=%0d exp=0", fwd_a); end
`endif
        tick();
        rd_mem = 0; regwrite_mem = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errs++;
            $display("FAIL lu_stall3 got=%b exp=0", stall); end
        tick();
        idle();
    endtask

    task automatic test_forwarding();
        idle();
`ifdef PIPELINE_CTRL_FORWARDING_EN
        rd_ex = 5; regwrite_ex = 1; rd_mem = 5; regwrite_mem = 1;
        rs_id = 5; use_rs_id = 1;
        #1;
        checks++;
        if (fwd_a !== 2'd1 || stall !== 1'b0) begin errs++;
            $display("FAIL fwd_ex got=%0d/%b exp=1/0", fwd_a, stall); end
        rs_id = 0;
        #1;
        checks++;
        if (fwd_a !== 2'd0) begin errs++;
            $display("FAIL fwd_r0 got=%0d exp=0", fwd_a); end
        rd_ex = 6; rt_id = 5; use_rt_id = 1;
        #1;
        checks++;
        if (fwd_b !== 2'd2) begin errs++;
            $display("FAIL fwd_mem got=%0d exp=2", fwd_b); end
`else
        rd_mem = 7; regwrite_mem = 1; rt_id = 7; use_rt_id = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errs++;
            $display("FAIL nouse_stall got=%b exp=0", stall); end
        use_rt_id = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || fwd_b !== 2'd0) begin errs++;
            $display("FAIL mem_stall got=%b/%0d exp=1/0", stall, fwd_b); end
        tick();
        idle();
        rd_ex = 0; regwrite_ex = 1; rs_id = 0; use_rs_id = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errs++;
            $display("FAIL r0_stall got=%b exp=0", stall); end
`endif
        tick();
        idle();
    endtask

    task automatic test_branch_irq();
        idle();
        irq = 1;
        #1;
        checks++;
        if (pcsrc !== 3'd0) begin errs++;
            $display("FAIL irq_same got=%0d exp=0", pcsrc); end
        tick();
        irq = 0; branch_taken_ex = 1;
        #1;
        checks++;
        if (pcsrc !== 3'd1 || irq_pending !== 1'b1) begin errs++;
            $display("FAIL br_win got=%0d/%b exp=1/1", pcsrc, irq_pending); end
        checks++;
        if ({flush_if_id, flush_id_ex, exc_save} !== 3'b110) begin errs++;
            $display("FAIL br_ctl got=%b exp=110",
                     {flush_if_id, flush_id_ex, exc_save}); end
        tick();
        branch_taken_ex = 0;
        #1;
        checks++;
        if (pcsrc !== 3'd5 || irq_pending !== 1'b1) begin errs++;
            $display("FAIL irq_take got=%0d/%b exp=5/1", pcsrc, irq_pending); end
        checks++;
        if ({flush_if_id, flush_id_ex, exc_save} !== 3'b111) begin errs++;
            $display("FAIL irq_ctl got=%b exp=111",
                     {flush_if_id, flush_id_ex, exc_save}); end
        tick();
        checks++;
        if (irq_pending !== 1'b0 || pcsrc !== 3'd0) begin errs++;
            $display("FAIL irq_clr got=%b/%0d exp=0/0", irq_pending, pcsrc); end
        idle();
    endtask

    task automatic test_kernel();
        idle();
        pc_id = 32'h8000_0100; irq = 1;
        tick();
        irq = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pcsrc !== 3'd0 || irq_pending !== 1'b1) begin errs++;
                $display("FAIL kern_hold%0d got=%0d/%b exp=0/1",
                         i, pcsrc, irq_pending); end
            tick();
        end
        pc_id = 32'h0040_0000;
        #1;
        checks++;
        if (pcsrc !== 3'd5) begin errs++;
            $display("FAIL kern_user got=%0d exp=5", pcsrc); end
        tick();
        checks++;
        if (irq_pending !== 1'b0) begin errs++;
            $display("FAIL kern_clr got=%b exp=0", irq_pending); end
        idle();
    endtask

    task automatic test_illop_stall();
        idle();
        rd_ex = 9; regwrite_ex = 1; memread_ex = 1;
        rs_id = 9; use_rs_id = 1; illop_id = 1;
        #1;
        checks++;
        if (pcsrc !== 3'd4 || stall !== 1'b0) begin errs++;
            $display("FAIL ill_pc got=%0d/%b exp=4/0", pcsrc, stall); end
        checks++;
        if ({flush_if_id, flush_id_ex, exc_save} !== 3'b101) begin errs++;
            $display("FAIL ill_ctl got=%b exp=101",
                     {flush_if_id, flush_id_ex, exc_save}); end
        tick();
        idle();
        #1;
        checks++;
        if (stall !== 1'b0) begin errs++;
            $display("FAIL ill_nofsm got=%b exp=0", stall); end
`ifndef PIPELINE_CTRL_FORWARDING_EN
        rd_ex = 9; regwrite_ex = 1; rs_id = 9; use_rs_id = 1;
        tick();
        rd_ex = 0; regwrite_ex = 0; illop_id = 1;
        #1;
        checks++;
        if (pcsrc !== 3'd4 || stall !== 1'b0) begin errs++;
            $display("FAIL ill_install got=%0d/%b exp=4/0", pcsrc, stall); end
        tick();
        idle();
        #1;
        checks++;
        if (stall !== 1'b0) begin errs++;
            $display("FAIL ill_exit got=%b exp=0", stall); end
`endif
        tick();
        idle();
    endtask

    task automatic test_jr_jump();
        idle();
        rd_ex = 10; regwrite_ex = 1; memread_ex = 1;
        rs_id = 10; use_rs_id = 1; jr_id = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || pcsrc !== 3'd0 || flush_if_id !== 1'b0) begin
            errs++;
            $display("FAIL jr_wait got=%b/%0d/%b exp=1/0/0",
                     stall, pcsrc, flush_if_id); end
        tick();
        rd_ex = 0; regwrite_ex = 0; memread_ex = 0;
        rd_mem = 10; regwrite_mem = 1;
`ifndef PIPELINE_CTRL_FORWARDING_EN
        #1;
        checks++;
        if (stall !== 1'b1 || pcsrc !== 3'd0) begin errs++;
            $display("FAIL jr_wait2 got=%b/%0d exp=1/0", stall, pcsrc); end
        tick();
        rd_mem = 0; regwrite_mem = 0;
`endif
        #1;
        checks++;
        if (pcsrc !== 3'd3 || flush_if_id !== 1'b1 || stall !== 1'b0) begin
            errs++;
            $display("FAIL jr_go got=%0d/%b/%b exp=3/1/0",
                     pcsrc, flush_if_id, stall); end
        tick();
        idle();
        jump_id = 1;
        #1;
        checks++;
        if (pcsrc !== 3'd2 || {flush_if_id, flush_id_ex} !== 2'b10) begin
            errs++;
            $display("FAIL jump got=%0d/%b exp=2/10",
                     pcsrc, {flush_if_id, flush_id_ex}); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        pc_id = 32'h8000_0000; irq = 1;
        rd_ex = 4; regwrite_ex = 1; rs_id = 4; use_rs_id = 1;
        tick();
`ifndef PIPELINE_CTRL_FORWARDING_EN
        checks++;
        if (dut.r_state !== ST_STALL) begin errs++;
            $display("FAIL rms_enter got=%0d exp=1", dut.r_state); end
`endif
        irq = 0; reset = 1; rd_ex = 0; regwrite_ex = 0;
        #1;
        checks++;
        if ({stall, flush_if_id, flush_id_ex, exc_save} !== 4'b0
            || pcsrc !== 3'd0) begin errs++;
            $display("FAIL rms_out got=%b/%0d exp=0000/0",
                     {stall, flush_if_id, flush_id_ex, exc_save}, pcsrc); end
        tick();
        reset = 0;
        idle();
        #1;
        checks++;
        if (dut.r_state !== ST_RUN || irq_pending !== 1'b0) begin errs++;
            $display("FAIL rms_clean got=%0d/%b exp=0/0",
                     dut.r_state, irq_pending); end
        checks++;
        if (stall !== 1'b0 || pcsrc !== 3'd0) begin errs++;
            $display("FAIL rms_idle got=%b/%0d exp=0/0", stall, pcsrc); end
        tick();
    endtask

    initial begin
        reset = 1;
        idle();
        tick();
        tick();
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch_irq();
        test_kernel();
        test_illop_stall();
        test_jr_jump();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
